// File: rtl/ntt_op_sequencer.sv
// Command sequencer in front of the NTT/PWM/INTT controller: queues 2-bit op
// commands, issues them one at a time with a start pulse, and tracks completion.
module ntt_op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  output logic        cmd_ready,
  output logic [1:0]  fsm_opcode,
  output logic        fsm_start,
  input  logic        fsm_finish,
  output logic        busy,
  output logic        op_done,
  output logic [1:0]  done_op,
  output logic [15:0] done_cnt,
  output logic        err_timeout,
  output logic [2:0]  dbg_state
);

  localparam logic [1:0] OP_NTT = 2'd0;
  localparam int         WW     = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  logic [1:0]    op_reg;
  logic [WW-1:0] wd;
  logic          wd_trip;

  // Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on FIFO occupancy, never on cmd_valid.
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && !empty;

  assign fsm_opcode = op_reg;
  assign fsm_start  = (state == S_START);
  assign op_done    = (state == S_GAP);
  assign busy       = (state != S_IDLE) || !empty;
  assign dbg_state  = state;

  always_comb begin
    state_d = state;
    wd_trip = 1'b0;
    unique case (state)
      S_IDLE:  if (!empty) state_d = S_SETUP;
      S_SETUP: state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN: begin
        // A finish arriving on the last watchdog cycle still completes the op.
        if (fsm_finish) begin
          state_d = S_GAP;
        end else if (wd == WW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          wd_trip = 1'b1;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_op;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      op_reg      <= OP_NTT;
      wd          <= '0;
      done_op     <= OP_NTT;
      done_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // The opcode register only moves on the IDLE->SETUP edge, so it is stable
      // for the whole START/RUN/GAP window.
      if (pop) op_reg <= mem[rd_ptr];
      if (state == S_START)    wd <= '0;
      else if (state == S_RUN) wd <= wd + WW'(1);
      if ((state == S_RUN) && fsm_finish) begin
        done_op  <= op_reg;
        done_cnt <= done_cnt + 16'd1;
      end
      if (wd_trip) err_timeout <= 1'b1;
    end
  end

endmodule
